// File: rtl/reg_writeback_unit.sv
// Register file write-back merge: ALU path, FIFO-buffered long path, pending scoreboard.
// Optional build macro WB_BYPASS_EN lets a long-path result skip an empty FIFO.
module reg_writeback_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     wb_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]   count_nxt;
    logic            alu_sel, handshake, pop, push, bypass;
    logic            we_nxt, ready_nxt, err_nxt;
    logic [4:0]      addr_nxt;
    logic [XLEN-1:0] data_nxt;
    logic [31:0]     pending_nxt;

    // Write-port selection, FIFO bookkeeping and scoreboard update
    always_comb begin
        alu_sel     = alu_valid && (alu_rd != 5'd0);
        handshake   = lsu_valid && lsu_ready;
        pop         = !alu_sel && (fifo_count != '0);
        bypass      = 1'b0;
`ifdef WB_BYPASS_EN
        bypass      = !alu_sel && (fifo_count == '0) && handshake && (lsu_rd != 5'd0);
`endif
        // rd=0 long-path results are consumed at the handshake and never stored
        push        = handshake && (lsu_rd != 5'd0) && !bypass;
        we_nxt      = alu_sel || pop || bypass;
        addr_nxt    = rf_waddr;
        data_nxt    = rf_wdata;
        if (alu_sel) begin
            addr_nxt = alu_rd;
            data_nxt = alu_data;
        end else if (pop) begin
            addr_nxt = mem[rd_ptr].rd;
            data_nxt = mem[rd_ptr].data;
        end else if (bypass) begin
            addr_nxt = lsu_rd;
            data_nxt = lsu_data;
        end

        wr_ptr_nxt  = push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_nxt  = pop  ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt   = fifo_count + CW'(push) - CW'(pop);
        ready_nxt   = count_nxt < CW'(DEPTH);

        // Error check uses the scoreboard as it stood before this edge's set
        err_nxt     = wb_err || (we_nxt && (addr_nxt != 5'd0) && !pending[addr_nxt]);

        pending_nxt = pending;
        if (we_nxt) begin
            pending_nxt[addr_nxt] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_waddr   <= 5'd0;
            rf_wdata   <= '0;
            pending    <= '0;
            fifo_count <= '0;
            wb_err     <= 1'b0;
            lsu_ready  <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            rf_we      <= we_nxt;
            rf_waddr   <= addr_nxt;
            rf_wdata   <= data_nxt;
            pending    <= pending_nxt;
            fifo_count <= count_nxt;
            wb_err     <= err_nxt;
            lsu_ready  <= ready_nxt;
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
        end
    end

    // FIFO storage; reset only clears pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{rd: lsu_rd, data: lsu_data};
        end
    end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed self-checking bench for reg_writeback_unit.
module tb_reg_writeback_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   alu_valid, lsu_valid, issue_valid;
    logic [4:0]             alu_rd, lsu_rd, issue_rd;
    logic [XLEN-1:0]        alu_data, lsu_data;
    logic                   lsu_ready, rf_we, wb_err;
    logic [4:0]             rf_waddr;
    logic [XLEN-1:0]        rf_wdata;
    logic [31:0]            pending;
    logic [$clog2(DEPTH):0] fifo_count;

    int total = 0;
    int bad   = 0;

    reg_writeback_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending(pending), .fifo_count(fifo_count), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        lsu_valid   = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        check({tag, ".we"},    64'(rf_we),    64'd1);
        check({tag, ".waddr"}, 64'(rf_waddr), 64'(a));
        check({tag, ".wdata"}, 64'(rf_wdata), 64'(d));
    endtask

    initial begin
        int  nxt;
        logic hs;
        rst_n = 1'b0;
        idle();
        alu_rd = '0; lsu_rd = '0; issue_rd = '0; alu_data = '0; lsu_data = '0;
        tick();
        tick();
        check("rst.we",      64'(rf_we),      64'd0);
        check("rst.waddr",   64'(rf_waddr),   64'd0);
        check("rst.wdata",   64'(rf_wdata),   64'd0);
        check("rst.pending", 64'(pending),    64'd0);
        check("rst.count",   64'(fifo_count), 64'd0);
        check("rst.err",     64'(wb_err),     64'd0);
        check("rst.ready",   64'(lsu_ready),  64'd1);
        rst_n = 1'b1;
        tick();

        // Basic ALU write with scoreboard
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick(); idle();
        check("t1.pend_set", 64'(pending), 64'h20);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        tick(); idle();
        expect_wr("t1.wr", 5'd5, 32'hDEADBEEF);
        check("t1.pend_clr", 64'(pending), 64'd0);
        check("t1.err",      64'(wb_err),  64'd0);
        tick();
        check("t1.we_off",   64'(rf_we),    64'd0);
        check("t1.hold",     64'(rf_wdata), 64'hDEADBEEF);

        // ALU busy every cycle while long path fills and then drains in order
        for (int r = 1; r <= 5; r++) begin
            issue_valid = 1'b1; issue_rd = 5'(r);
            tick();
        end
        issue_rd = 5'd10;
        tick(); idle();
        check("t2.pend", 64'(pending), 64'h0000_043E);
        nxt = 1;
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA000 + 32'(c);
            issue_valid = (c < 5); issue_rd = 5'd10;
            lsu_valid = 1'b1; lsu_rd = 5'(nxt); lsu_data = 32'h100 + 32'(nxt);
            hs = lsu_ready;
            tick();
            if (hs) nxt++;
            expect_wr("t2.alu", 5'd10, 32'hA000 + 32'(c));
            if (c == 3) begin
                check("t2.full_cnt",   64'(fifo_count), 64'd4);
                check("t2.full_ready", 64'(lsu_ready),  64'd0);
            end
        end
        alu_valid = 1'b0; issue_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            hs = lsu_valid && lsu_ready;
            tick();
            if (hs) lsu_valid = 1'b0;
            expect_wr("t2.drain", 5'(k), 32'h100 + 32'(k));
        end
        idle();
        check("t2.cnt0",  64'(fifo_count), 64'd0);
        check("t2.pend0", 64'(pending),    64'd0);
        check("t2.err",   64'(wb_err),     64'd0);
        tick();
        check("t2.we_off", 64'(rf_we), 64'd0);

        // ALU and long path in the same cycle, empty FIFO
        issue_valid = 1'b1; issue_rd = 5'd3; tick();
        issue_rd = 5'd7; tick(); idle();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
        tick(); idle();
        expect_wr("t3.alu", 5'd3, 32'h33);
        check("t3.cnt1", 64'(fifo_count), 64'd1);
        tick();
        expect_wr("t3.lsu", 5'd7, 32'h77);
        check("t3.cnt0", 64'(fifo_count), 64'd0);
        tick();
        check("t3.we_off", 64'(rf_we), 64'd0);

        // Lone long-path result: bypass latency vs FIFO latency
        issue_valid = 1'b1; issue_rd = 5'd7; tick(); idle();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h7777;
        tick(); idle();
`ifdef WB_BYPASS_EN
        expect_wr("t3.byp", 5'd7, 32'h7777);
        check("t3.byp_cnt", 64'(fifo_count), 64'd0);
`else
        check("t3.nobyp_we",  64'(rf_we),      64'd0);
        check("t3.nobyp_cnt", 64'(fifo_count), 64'd1);
        tick();
        expect_wr("t3.nobyp", 5'd7, 32'h7777);
`endif
        tick();
        check("t3.err", 64'(wb_err), 64'd0);

        // ALU result to x0 is dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
        tick(); idle();
        check("t4.we",    64'(rf_we),    64'd0);
        check("t4.waddr", 64'(rf_waddr), 64'd7);
        check("t4.wdata", 64'(rf_wdata), 64'h7777);
        check("t4.pend",  64'(pending),  64'd0);
        check("t4.err",   64'(wb_err),   64'd0);

        // Write to a non-pending register raises sticky error
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick(); idle();
        expect_wr("t5.wr", 5'd9, 32'h99);
        check("t5.err", 64'(wb_err), 64'd1);
        repeat (3) tick();
        check("t5.sticky", 64'(wb_err), 64'd1);

        // Mid-operation reset flushes FIFO and scoreboard
        for (int c = 0; c < 4; c++) begin
            alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h900 + 32'(c);
            issue_valid = 1'b1; issue_rd = 5'(4 + c);
            lsu_valid = (c < 3); lsu_rd = 5'(20 + c); lsu_data = 32'h2000 + 32'(c);
            tick();
        end
        idle();
        check("t6.pre_cnt",  64'(fifo_count), 64'd3);
        check("t6.pre_pend", 64'(pending),    64'hF0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.cnt",   64'(fifo_count), 64'd0);
        check("t6.pend",  64'(pending),    64'd0);
        check("t6.we",    64'(rf_we),      64'd0);
        check("t6.ready", 64'(lsu_ready),  64'd1);
        check("t6.err",   64'(wb_err),     64'd0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
